// File: rtl/mod_updown_counter_pkg.sv
// Shared constants for the up/down event counter: direction and boundary-mode encodings.
package mod_updown_counter_pkg;

  localparam logic CNT_UP    = 1'b1;
  localparam logic CNT_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage : mod_updown_counter_pkg

// File: rtl/mod_updown_counter_cnt_prescaler.sv
// Divides enabled cycles by PRESCALE; step_tick is high on the enabled cycle that closes a period.
module cnt_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clock,
  input  logic clear_n,
  input  logic enable,
  input  logic restart,
  output logic step_tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] psc;

  // restart discards any partial period so the next tick is a full PRESCALE cycles away
  assign step_tick = enable & ~restart & (psc == LAST);

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      psc <= '0;
    end else if (restart) begin
      psc <= '0;
    end else if (enable) begin
      psc <= (psc == LAST) ? '0 : psc + PW'(1);
    end
  end

endmodule : cnt_prescaler

// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with modulus, wrap/saturate, parallel load, prescaled enable,
// terminal-count pulse and sticky overflow.
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 255,
  parameter int PRESCALE = 1
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             enable,
  input  logic             up_down,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

  logic             step_tick;
  logic             step;
  logic             boundary;
  logic [WIDTH-1:0] next_count;
  logic             next_ovf;

  generate
    if (PRESCALE > 1) begin : g_psc
      cnt_prescaler #(
        .PRESCALE (PRESCALE)
      ) u_psc (
        .clock     (clock),
        .clear_n   (clear_n),
        .enable    (enable),
        .restart   (load),
        .step_tick (step_tick)
      );
    end else begin : g_nopsc
      assign step_tick = enable;
    end
  endgenerate

  assign step = step_tick & ~load;

  // A boundary event is any step taken at the bound in the step direction, in either mode
  always_comb begin
    next_count = count;
    boundary   = 1'b0;
    if (load) begin
      next_count = (load_value > MAX_V) ? MAX_V : load_value;
    end else if (step) begin
      if (up_down == CNT_UP) begin
        if (count == MAX_V) begin
          boundary   = 1'b1;
          next_count = (sat_mode == MODE_SAT) ? MAX_V : '0;
        end else begin
          next_count = count + WIDTH'(1);
        end
      end else begin
        if (count == '0) begin
          boundary   = 1'b1;
          next_count = (sat_mode == MODE_SAT) ? '0 : MAX_V;
        end else begin
          next_count = count - WIDTH'(1);
        end
      end
    end
  end

  assign next_ovf = boundary | (overflow & ~clr_ovf);

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      count    <= '0;
      tc       <= 1'b0;
      overflow <= 1'b0;
    end else begin
      count    <= next_count;
      tc       <= boundary;
      overflow <= next_ovf;
    end
  end

endmodule : mod_updown_counter

// File: tb/tb_mod_updown_counter.sv
// Directed self-checking bench: three counter instances (default, MAX_VAL=9, PRESCALE=4).
module tb_mod_updown_counter;

  logic       clock = 1'b0;
  logic       clear_n;
  logic       enable;
  logic       up_down;
  logic       sat_mode;
  logic       load;
  logic [7:0] load_value;
  logic       clr_ovf;

  logic [7:0] count_a, count_b, count_c;
  logic       tc_a, tc_b, tc_c;
  logic       ovf_a, ovf_b, ovf_c;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clock = ~clock;

  mod_updown_counter dut_a (
    .clock(clock), .clear_n(clear_n), .enable(enable), .up_down(up_down),
    .sat_mode(sat_mode), .load(load), .load_value(load_value), .clr_ovf(clr_ovf),
    .count(count_a), .tc(tc_a), .overflow(ovf_a)
  );

  mod_updown_counter #(.WIDTH(8), .MAX_VAL(9), .PRESCALE(1)) dut_b (
    .clock(clock), .clear_n(clear_n), .enable(enable), .up_down(up_down),
    .sat_mode(sat_mode), .load(load), .load_value(load_value), .clr_ovf(clr_ovf),
    .count(count_b), .tc(tc_b), .overflow(ovf_b)
  );

  mod_updown_counter #(.WIDTH(8), .MAX_VAL(255), .PRESCALE(4)) dut_c (
    .clock(clock), .clear_n(clear_n), .enable(enable), .up_down(up_down),
    .sat_mode(sat_mode), .load(load), .load_value(load_value), .clr_ovf(clr_ovf),
    .count(count_c), .tc(tc_c), .overflow(ovf_c)
  );

  typedef struct {
    string      name;
    logic       load;
    logic [7:0] load_value;
    logic       enable;
    logic       up_down;
    logic       sat_mode;
    logic       clr_ovf;
    logic [7:0] exp_count;
    logic       exp_tc;
    logic       exp_ovf;
  } vec_t;

  task automatic applyStimulus(input logic cn, input logic ld, input logic [7:0] lv,
                               input logic en, input logic ud, input logic sm,
                               input logic co);
    clear_n    = cn;
    load       = ld;
    load_value = lv;
    enable     = en;
    up_down    = ud;
    sat_mode   = sm;
    clr_ovf    = co;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act_count,
                             input logic act_tc, input logic act_ovf,
                             input logic [7:0] exp_count, input logic exp_tc,
                             input logic exp_ovf);
    n_compared++;
    if ({act_count, act_tc, act_ovf} !== {exp_count, exp_tc, exp_ovf}) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got count=%0d tc=%b ovf=%b, expected count=%0d tc=%b ovf=%b",
               name, act_count, act_tc, act_ovf, exp_count, exp_tc, exp_ovf);
    end
  endtask

  vec_t vecs[$];

  initial begin
    // MAX_VAL=9 instance: down/wrap, saturate, clamp, direction change, flag priority
    vecs.push_back('{"t2_load2",       1'b1, 8'd2,   1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0});
    vecs.push_back('{"t2_dn1",         1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0});
    vecs.push_back('{"t2_dn0",         1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0});
    vecs.push_back('{"t2_wrap9",       1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 8'd9, 1'b1, 1'b1});
    vecs.push_back('{"t2_dn8",         1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 8'd8, 1'b0, 1'b1});
    vecs.push_back('{"t3_load7",       1'b1, 8'd7,   1'b0, 1'b1, 1'b1, 1'b1, 8'd7, 1'b0, 1'b0});
    vecs.push_back('{"t3_up8",         1'b0, 8'd0,   1'b1, 1'b1, 1'b1, 1'b0, 8'd8, 1'b0, 1'b0});
    vecs.push_back('{"t3_up9",         1'b0, 8'd0,   1'b1, 1'b1, 1'b1, 1'b0, 8'd9, 1'b0, 1'b0});
    vecs.push_back('{"t3_sat1",        1'b0, 8'd0,   1'b1, 1'b1, 1'b1, 1'b0, 8'd9, 1'b1, 1'b1});
    vecs.push_back('{"t3_sat2",        1'b0, 8'd0,   1'b1, 1'b1, 1'b1, 1'b0, 8'd9, 1'b1, 1'b1});
    vecs.push_back('{"t3_sat3",        1'b0, 8'd0,   1'b1, 1'b1, 1'b1, 1'b0, 8'd9, 1'b1, 1'b1});
    vecs.push_back('{"t3_disabled",    1'b0, 8'd0,   1'b0, 1'b1, 1'b1, 1'b0, 8'd9, 1'b0, 1'b1});
    vecs.push_back('{"t5_clamp200",    1'b1, 8'd200, 1'b1, 1'b1, 1'b0, 1'b0, 8'd9, 1'b0, 1'b1});
    vecs.push_back('{"t5_load5",       1'b1, 8'd5,   1'b1, 1'b1, 1'b0, 1'b0, 8'd5, 1'b0, 1'b1});
    vecs.push_back('{"t5_up6",         1'b0, 8'd0,   1'b1, 1'b1, 1'b0, 1'b0, 8'd6, 1'b0, 1'b1});
    vecs.push_back('{"dir_change_dn5", 1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b1});
    vecs.push_back('{"t6_clr_alone",   1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b1, 8'd5, 1'b0, 1'b0});
    vecs.push_back('{"t6_load9",       1'b1, 8'd9,   1'b0, 1'b1, 1'b0, 1'b0, 8'd9, 1'b0, 1'b0});
    vecs.push_back('{"t6_set_wins",    1'b0, 8'd0,   1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 1'b1, 1'b1});
    vecs.push_back('{"t6_hold",        1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1});
    vecs.push_back('{"t6_clr",         1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0});
    vecs.push_back('{"sat_dn_at0",     1'b0, 8'd0,   1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1});
    vecs.push_back('{"sat_change_only",1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1});

    // Test 1: reset, then free-run up through the 255 -> 0 wrap
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t1_reset", count_a, tc_a, ovf_a, 8'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 260; i++) begin
      applyStimulus(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("t1_up_%0d", i), count_a, tc_a, ovf_a,
                  8'(i % 256), (i == 256), (i >= 256));
    end

    // Tests 2, 3, 5, 6 on the MAX_VAL=9 instance
    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].load, vecs[i].load_value, vecs[i].enable,
                    vecs[i].up_down, vecs[i].sat_mode, vecs[i].clr_ovf);
      checkOutput(vecs[i].name, count_b, tc_b, ovf_b,
                  vecs[i].exp_count, vecs[i].exp_tc, vecs[i].exp_ovf);
    end

    // Test 4: prescale by 4 with an enable gap
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t4_reset", count_c, tc_c, ovf_c, 8'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("t4_en_%0d", k), count_c, tc_c, ovf_c, 8'(k / 4), 1'b0, 1'b0);
    end
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("t4_off_%0d", k), count_c, tc_c, ovf_c, 8'd2, 1'b0, 1'b0);
    end
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("t4_reen_%0d", k), count_c, tc_c, ovf_c,
                  (k == 4) ? 8'd3 : 8'd2, 1'b0, 1'b0);
    end

    // Test 5 (prescaled): a load mid-period restarts the prescaler
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_psc_mid", count_c, tc_c, ovf_c, 8'd3, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'd200, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_psc_load", count_c, tc_c, ovf_c, 8'd200, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("t5_psc_restart_%0d", k), count_c, tc_c, ovf_c,
                  (k == 4) ? 8'd201 : 8'd200, 1'b0, 1'b0);
    end

    // Test 6 (prescaled): overflow, then reset mid-prescale
    applyStimulus(1'b1, 1'b1, 8'd255, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("t6_psc_wrap_%0d", k), count_c, tc_c, ovf_c,
                  (k == 4) ? 8'd0 : 8'd255, (k == 4), (k == 4));
    end
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_mid_reset", count_c, tc_c, ovf_c, 8'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("t6_after_reset_%0d", k), count_c, tc_c, ovf_c,
                  (k == 4) ? 8'd1 : 8'd0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_mod_updown_counter

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
Parametrised successor to the team's free-running 8-bit up counter. It adds:
- up/down direction
- programmable modulus
- wrap or saturate mode
- parallel load
- count-enable with a built-in prescaler
- terminal-count pulse and sticky overflow flag

It is the common event/timebase counter for the lab designs, instantiated wherever a plain up counter was used before.

Parameters:
WIDTH, 8, bit width of count and load_value
MAX_VAL, 255, highest count value (modulus-1); must satisfy 1 <= MAX_VAL <= 2**WIDTH-1
PRESCALE, 1, enabled clock cycles per count step; 1 = step every enabled cycle; must be >= 1

Ports:
clock  input  1  rising-edge clock, single domain
clear_n  input  1  synchronous active-low reset
enable  input  1  count enable; low freezes count and prescaler
up_down  input  1  1 = count up, 0 = count down; sampled on each step cycle
sat_mode  input  1  1 = saturate at bounds, 0 = wrap around
load  input  1  synchronous parallel load
load_value  input  WIDTH  value to load
clr_ovf  input  1  clears sticky overflow flag
count  output  WIDTH  current count
tc  output  1  one-cycle terminal-count pulse
overflow  output  1  sticky boundary-event flag

Behaviour:
- Reset is synchronous and active-low, on clock only. While clear_n=0 at a rising edge:
  - count=0, tc=0, overflow=0, prescaler=0.
  - All other inputs are ignored.
  - Reset asserted mid-count or mid-prescale abandons the partial prescale.
- Priority per edge: clear_n low > load > step > hold.
- Load:
  - count <= min(load_value, MAX_VAL).
  - Prescaler is set to 0; tc=0; overflow unchanged.
  - Load wins over a same-cycle step.
- Prescaler:
  - Internal counter psc counts 0..PRESCALE-1, advancing only when enable=1 and load=0.
  - A step occurs on the edge where enable=1 and psc==PRESCALE-1; psc then returns to 0.
  - With PRESCALE=1 no psc register is needed; every enabled cycle steps.
- Step, up (up_down=1):
  - count<MAX_VAL: count+1.
  - count==MAX_VAL: wrap mode -> 0; sat mode -> hold at MAX_VAL.
- Step, down (up_down=0):
  - count>0: count-1.
  - count==0: wrap mode -> MAX_VAL; sat mode -> hold at 0.
- Boundary event: a step taken while count sits at the bound in the step direction (MAX_VAL going up, 0 going down), in either mode.
- tc: registered. It is 1 for exactly one cycle, coincident with the post-step count value, after each boundary event; 0 otherwise, including hold, load and disabled cycles. In sat mode, each further step at the bound re-pulses tc.
- overflow:
  - Set on any boundary event; cleared when clr_ovf=1.
  - Simultaneous set and clear: set wins.
  - Unaffected by load.
- Direction change takes effect on the next step with no latency penalty. Changing sat_mode has no immediate effect on count.
- If a load of a value above MAX_VAL is followed by steps, the count stays within 0..MAX_VAL (the load clamps it).
- Arithmetic: all compare/add in WIDTH bits. Count is never outside 0..MAX_VAL; no carry out beyond WIDTH.
- Latency: count, tc and overflow update on the edge that samples the inputs (one-cycle registered).

Decomposition:
- Shared package/header holds the direction constants CNT_UP=1'b1 and CNT_DN=1'b0, and the mode constants MODE_WRAP=1'b0 and MODE_SAT=1'b1.
- One natural sub-module: cnt_prescaler, parameter PRESCALE, with ports clock, clear_n, enable, restart (= load) and step_tick. Instantiated only when PRESCALE>1; otherwise step_tick = enable.
- Core next-count/boundary logic stays in mod_updown_counter.

Test Plan:
1. Reset and count up. Defaults, clear_n=0 for 2 cycles then 1, enable=1, up_down=1, sat_mode=0, 260 cycles. Required: count 0,1,...,255,0,1,2,3; tc high only on the cycle count becomes 0; overflow=1 afterwards.
2. Count down, wrap. MAX_VAL=9, load 2 then enable, up_down=0, wrap mode. Required: count 2,1,0,9,8; tc pulses with the 9; overflow set.
3. Saturate up. MAX_VAL=9, sat_mode=1, load 7, count up 5 steps. Required: count 8,9,9,9,9; tc high on each of the three held steps; count never 0.
4. Prescaler and enable. PRESCALE=4, enable=1 for 8 cycles, low 3 cycles, high 4 cycles. Required: count reaches 2 after 8 cycles, holds while enable is low, reaches 3 on the 4th re-enabled cycle.
5. Load priority and clamp. MAX_VAL=9, assert load with load_value=200 on a step edge. Required: count=9 (clamp), no tc, psc restarts. Then load 5 and step up gives 6.
6. Flags and reset. Create overflow, then assert clr_ovf in the same cycle as a boundary event. Required: overflow stays 1. clr_ovf alone clears it to 0. clear_n=0 mid-prescale zeros count, tc, overflow and psc; the next step comes PRESCALE enabled cycles after release.
